attack_engine: RTL and testbench

// - Sequential, parametrised successor to the combinational attack decoder for the naval-battle game.
// - Holds a ROWS x COLS fleet map loaded at setup and accepts one shot per handshake.
// - Reports hit, miss, repeat, invalid and sunk per shot; flags game over when every ship is sunk.
// - Sits between the player-input decoder and the display/score logic.

---
 rtl/attack_pkg.sv | 22 ++
 rtl/ship_tracker.sv | 52 +++++
 rtl/attack_engine.sv | 189 ++++++++++++++++++
 tb/tb_attack_engine.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/attack_pkg.sv
// Shared types and width helpers for the naval-battle attack engine.
package attack_pkg;

  typedef enum logic [2:0] {LOAD, PLAY, EVAL, RESP, OVER} state_e;

  // Per-shot result flags; the ship id travels alongside because its width is a parameter.
  typedef struct packed {
    logic hit;
    logic rep;
    logic inval;
    logic sunk;
  } res_flags_t;

  function automatic int id_w(input int n_ships);
    return $clog2(n_ships + 1);
  endfunction

  function automatic int cnt_w(input int rows, input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/ship_tracker.sv
// Per-ship remaining-cell counters with sunk mask and all-sunk flag.
module ship_tracker
  import attack_pkg::*;
#(
  parameter int N_SHIPS = 6,
  parameter int ID_W    = 3,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               inc_en_i,
  input  logic [ID_W-1:0]    inc_id_i,
  input  logic               dec_en_i,
  input  logic [ID_W-1:0]    dec_id_i,
  output logic               last_o,
  output logic [N_SHIPS-1:0] sunk_mask_o,
  output logic               all_sunk_o
);

  logic [CNT_W-1:0]   rem_q [N_SHIPS];
  logic [N_SHIPS-1:0] sunk_q;

  // Counters grow while loading and shrink on first hits; a 1->0 step marks the ship sunk.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      for (int i = 0; i < N_SHIPS; i++) rem_q[i] <= '0;
      sunk_q <= '0;
    end else begin
      for (int i = 0; i < N_SHIPS; i++) begin
        if (inc_en_i && inc_id_i == ID_W'(i + 1)) begin
          rem_q[i] <= rem_q[i] + CNT_W'(1);
        end else if (dec_en_i && dec_id_i == ID_W'(i + 1)) begin
          rem_q[i] <= rem_q[i] - CNT_W'(1);
          if (rem_q[i] == CNT_W'(1)) sunk_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_o     = 1'b0;
    all_sunk_o = 1'b1;
    for (int i = 0; i < N_SHIPS; i++) begin
      if (dec_id_i == ID_W'(i + 1) && rem_q[i] == CNT_W'(1)) last_o = 1'b1;
      if (rem_q[i] != '0) all_sunk_o = 1'b0;
    end
  end

  assign sunk_mask_o = sunk_q;

endmodule

// File: rtl/attack_engine.sv
// Sequential attack engine: fleet map, shot map and game FSM.
// Optional SHOT_CNT_EN adds saturating shot_cnt/miss_cnt outputs.
module attack_engine
  import attack_pkg::*;
#(
  parameter int  ROWS    = 8,
  parameter int  COLS    = 8,
  parameter int  N_SHIPS = 6,
  localparam int R_W     = $clog2(ROWS),
  localparam int C_W     = $clog2(COLS),
  localparam int ID_W    = id_w(N_SHIPS),
  localparam int CNT_W   = cnt_w(ROWS, COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [R_W-1:0]     cfg_row,
  input  logic [C_W-1:0]     cfg_col,
  input  logic [ID_W-1:0]    cfg_ship,
  input  logic               cfg_start,
  input  logic               new_game,
  output logic               cfg_err,
  input  logic               atk_valid,
  output logic               atk_ready,
  input  logic [R_W-1:0]     atk_row,
  input  logic [C_W-1:0]     atk_col,
  output logic               res_valid,
  output logic               res_hit,
  output logic               res_repeat,
  output logic               res_inval,
  output logic               res_sunk,
  output logic [ID_W-1:0]    res_ship,
  output logic [N_SHIPS-1:0] sunk_mask,
  output logic               game_over
`ifdef SHOT_CNT_EN
  ,
  output logic [CNT_W-1:0]   shot_cnt,
  output logic [CNT_W-1:0]   miss_cnt
`endif
);

  localparam int             CELLS  = ROWS * COLS;
  localparam int             IDX_W  = $clog2(CELLS);
  localparam logic [R_W:0]   ROWS_L = (R_W + 1)'(ROWS);
  localparam logic [C_W:0]   COLS_L = (C_W + 1)'(COLS);
  localparam logic [ID_W-1:0] NS_L  = ID_W'(N_SHIPS);

  state_e            state_q, state_d;
  logic [R_W-1:0]    row_q;
  logic [C_W-1:0]    col_q;
  logic [ID_W-1:0]   map_q [CELLS];
  logic [CELLS-1:0]  shot_q;
  logic              cfg_err_q, res_valid_q;
  res_flags_t        flags_q, eval_flags_s;
  logic [ID_W-1:0]   ship_q, eval_ship_s, cell_id_s;
  logic [IDX_W-1:0]  cfg_idx_s, atk_idx_s;
  logic              cfg_ok_s, load_wr_s, load_err_s, inc_en_s;
  logic              atk_in_s, was_shot_s, dec_en_s, last_s, all_sunk_s;
  logic              atk_ready_s, game_over_s;

  assign cfg_idx_s  = IDX_W'(cfg_row) * IDX_W'(COLS) + IDX_W'(cfg_col);
  assign atk_idx_s  = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
  assign cfg_ok_s   = ({1'b0, cfg_row} < ROWS_L) && ({1'b0, cfg_col} < COLS_L)
                      && (cfg_ship <= NS_L) && (map_q[cfg_idx_s] == '0);
  assign load_wr_s  = (state_q == LOAD) && cfg_we && cfg_ok_s;
  assign load_err_s = (state_q == LOAD) && cfg_we && !cfg_ok_s;
  assign inc_en_s   = load_wr_s && (cfg_ship != '0);
  assign atk_in_s   = ({1'b0, row_q} < ROWS_L) && ({1'b0, col_q} < COLS_L);
  assign cell_id_s  = map_q[atk_idx_s];
  assign was_shot_s = shot_q[atk_idx_s];
  assign dec_en_s   = (state_q == EVAL) && atk_in_s && !was_shot_s && (cell_id_s != '0);

  ship_tracker #(.N_SHIPS(N_SHIPS), .ID_W(ID_W), .CNT_W(CNT_W)) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (new_game),
    .inc_en_i   (inc_en_s),
    .inc_id_i   (cfg_ship),
    .dec_en_i   (dec_en_s),
    .dec_id_i   (cell_id_s),
    .last_o     (last_s),
    .sunk_mask_o(sunk_mask),
    .all_sunk_o (all_sunk_s)
  );

  // Shot classification from the captured coordinate.
  always_comb begin
    eval_flags_s = '0;
    eval_ship_s  = '0;
    if (!atk_in_s) begin
      eval_flags_s.inval = 1'b1;
    end else begin
      eval_flags_s.hit  = (cell_id_s != '0);
      eval_flags_s.rep  = was_shot_s;
      eval_flags_s.sunk = !was_shot_s && (cell_id_s != '0) && last_s;
      eval_ship_s       = cell_id_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  // FSM next state; a start with no ship cells (counting a same-cycle write) ends the game at once.
  always_comb begin
    state_d = state_q;
    if (new_game) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (cfg_start) state_d = (all_sunk_s && !inc_en_s) ? OVER : PLAY;
                 else           state_d = LOAD;
        PLAY:    if (atk_valid) state_d = EVAL;
                 else           state_d = PLAY;
        EVAL:    state_d = RESP;
        RESP:    state_d = all_sunk_s ? OVER : PLAY;
        OVER:    state_d = OVER;
        default: state_d = LOAD;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    atk_ready_s = (state_q == PLAY);
    game_over_s = (state_q == OVER);
  end

  // Maps, captured shot and result pulse; new_game discards any pending result.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      for (int i = 0; i < CELLS; i++) map_q[i] <= '0;
      shot_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cfg_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      flags_q     <= '0;
      ship_q      <= '0;
    end else begin
      cfg_err_q   <= load_err_s;
      res_valid_q <= (state_q == EVAL);
      if (load_wr_s) map_q[cfg_idx_s] <= cfg_ship;
      if (state_q == PLAY && atk_valid) begin
        row_q <= atk_row;
        col_q <= atk_col;
      end
      if (state_q == EVAL) begin
        flags_q <= eval_flags_s;
        ship_q  <= eval_ship_s;
        if (atk_in_s) shot_q[atk_idx_s] <= 1'b1;
      end else begin
        flags_q <= '0;
        ship_q  <= '0;
      end
    end
  end

`ifdef SHOT_CNT_EN
  logic [CNT_W-1:0] shot_cnt_q, miss_cnt_q;

  // Saturating counters of fresh valid shots and of fresh water shots.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      shot_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == EVAL && atk_in_s && !was_shot_s) begin
      if (shot_cnt_q != '1) shot_cnt_q <= shot_cnt_q + CNT_W'(1);
      if (cell_id_s == '0 && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign shot_cnt = shot_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

  assign cfg_err    = cfg_err_q;
  assign atk_ready  = atk_ready_s;
  assign game_over  = game_over_s;
  assign res_valid  = res_valid_q;
  assign res_hit    = flags_q.hit;
  assign res_repeat = flags_q.rep;
  assign res_inval  = flags_q.inval;
  assign res_sunk   = flags_q.sunk;
  assign res_ship   = ship_q;

endmodule

// File: tb/tb_attack_engine.sv
// Directed self-checking bench for attack_engine on a 6x8 grid with 6 ships.
module tb_attack_engine;

  logic       clk = 1'b0;
  logic       reset, cfg_we, cfg_start, new_game, atk_valid;
  logic [2:0] cfg_row, cfg_col, cfg_ship, atk_row, atk_col;
  logic       cfg_err, atk_ready, res_valid, res_hit, res_repeat, res_inval, res_sunk, game_over;
  logic [2:0] res_ship;
  logic [5:0] sunk_mask;
`ifdef SHOT_CNT_EN
  logic [5:0] shot_cnt, miss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0]  res_vec;
  logic [16:0] all_outs;
  logic [7:0]  r_res;
  logic [5:0]  r_mask;
  logic        err;

  assign res_vec  = {res_valid, res_hit, res_repeat, res_inval, res_sunk, res_ship};
  assign all_outs = {cfg_err, atk_ready, res_vec, sunk_mask, game_over};

  attack_engine #(.ROWS(6), .COLS(8), .N_SHIPS(6)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col),
    .cfg_ship(cfg_ship), .cfg_start(cfg_start), .new_game(new_game), .cfg_err(cfg_err),
    .atk_valid(atk_valid), .atk_ready(atk_ready), .atk_row(atk_row), .atk_col(atk_col),
    .res_valid(res_valid), .res_hit(res_hit), .res_repeat(res_repeat), .res_inval(res_inval),
    .res_sunk(res_sunk), .res_ship(res_ship), .sunk_mask(sunk_mask), .game_over(game_over)
`ifdef SHOT_CNT_EN
    , .shot_cnt(shot_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [2:0] c, input logic [2:0] id, output logic e);
    cfg_we = 1'b1; cfg_row = r; cfg_col = c; cfg_ship = id;
    cyc();
    e = cfg_err;
    cfg_we = 1'b0;
  endtask

  // One shot: checks the handshake timing and leaves the result in r_res/r_mask.
  task automatic shoot(input logic [2:0] r, input logic [2:0] c);
    check_val("ready_before", 32'(atk_ready), 32'd1);
    atk_valid = 1'b1; atk_row = r; atk_col = c;
    cyc();
    atk_valid = 1'b0;
    check_val("n1_ready_low", 32'({atk_ready, res_valid}), 32'd0);
    cyc();
    r_res  = res_vec;
    r_mask = sunk_mask;
    check_val("n2_ready_low", 32'(atk_ready), 32'd0);
    cyc();
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_start = 1'b0; new_game = 1'b0; atk_valid = 1'b0;
    cfg_row = '0; cfg_col = '0; cfg_ship = '0; atk_row = '0; atk_col = '0;
    cyc(); cyc();
    check_val("reset_outs", 32'(all_outs), 32'd0);
    reset = 1'b0;
    cyc();

    // Game 1: ship 1 on two cells, sunk in two shots.
    wr(3'd0, 3'd0, 3'd1, err); check_val("g1_wr0_err", 32'(err), 32'd0);
    wr(3'd0, 3'd1, 3'd1, err); check_val("g1_wr1_err", 32'(err), 32'd0);
    cfg_start = 1'b1; cyc(); cfg_start = 1'b0;
    shoot(3'd0, 3'd0);
    check_val("g1_hit", 32'(r_res), 32'h0C1);
    check_val("g1_mid_over", 32'({game_over, atk_ready}), 32'b01);
    shoot(3'd0, 3'd1);
    check_val("g1_sunk", 32'(r_res), 32'h0C9);
    check_val("g1_mask", 32'(r_mask), 32'b000001);
    check_val("g1_over", 32'({game_over, atk_ready, res_vec}), 32'h200);
    new_game = 1'b1; cyc(); new_game = 1'b0;
    check_val("newgame_clear", 32'({game_over, atk_ready, sunk_mask}), 32'd0);

    // Game 2: load errors, invalid/water/repeat shots, one-cell ship.
    wr(3'd2, 3'd2, 3'd3, err); check_val("g2_wr_ok", 32'(err), 32'd0);
    wr(3'd2, 3'd2, 3'd4, err); check_val("g2_wr_occupied", 32'(err), 32'd1);
    wr(3'd7, 3'd0, 3'd1, err); check_val("g2_wr_row7", 32'(err), 32'd1);
    wr(3'd0, 3'd0, 3'd7, err); check_val("g2_wr_bad_id", 32'(err), 32'd1);
    wr(3'd4, 3'd5, 3'd2, err); check_val("g2_wr_ship2", 32'(err), 32'd0);
    cfg_we = 1'b1; cfg_row = 3'd4; cfg_col = 3'd6; cfg_ship = 3'd2; cfg_start = 1'b1;
    cyc();
    cfg_we = 1'b0; cfg_start = 1'b0;
    check_val("g2_we_start", 32'({cfg_err, atk_ready, game_over}), 32'b010);
    shoot(3'd7, 3'd0); check_val("g2_inval", 32'(r_res), 32'h090);
    shoot(3'd3, 3'd3); check_val("g2_water", 32'(r_res), 32'h080);
    shoot(3'd3, 3'd3); check_val("g2_water_rep", 32'(r_res), 32'h0A0);
`ifdef SHOT_CNT_EN
    check_val("g2_cnt_water", 32'({shot_cnt, miss_cnt}), 32'({6'd1, 6'd1}));
`endif
    shoot(3'd2, 3'd2); check_val("g2_sink3", 32'(r_res), 32'h0CB);
    check_val("g2_mask3", 32'(r_mask), 32'b000100);
    shoot(3'd2, 3'd2); check_val("g2_rep3", 32'(r_res), 32'h0E3);
`ifdef SHOT_CNT_EN
    check_val("g2_cnt_hit", 32'({shot_cnt, miss_cnt}), 32'({6'd2, 6'd1}));
`endif

    // Back-to-back shots with atk_valid held.
    atk_valid = 1'b1; atk_row = 3'd4; atk_col = 3'd5;
    check_val("b2b_ready_n", 32'(atk_ready), 32'd1);
    cyc();
    atk_col = 3'd6;
    check_val("b2b_n1", 32'({atk_ready, res_vec}), 32'd0);
    cyc();
    check_val("b2b_n2", 32'({atk_ready, res_vec}), 32'h0C2);
    cyc();
    check_val("b2b_n3", 32'({atk_ready, res_vec}), 32'h100);
    cyc();
    check_val("b2b_n4", 32'(atk_ready), 32'd0);
    cyc();
    atk_valid = 1'b0;
    check_val("b2b_n5", 32'(res_vec), 32'h0CA);
    check_val("b2b_mask", 32'(sunk_mask), 32'b000110);
    cyc();
    check_val("b2b_over", 32'({game_over, atk_ready}), 32'b10);

    // Reset while a shot is in EVAL: result discarded.
    new_game = 1'b1; cyc(); new_game = 1'b0;
    wr(3'd1, 3'd1, 3'd5, err);
    cfg_start = 1'b1; cyc(); cfg_start = 1'b0;
    atk_valid = 1'b1; atk_row = 3'd1; atk_col = 3'd1;
    cyc();
    atk_valid = 1'b0;
    check_val("eval_entered", 32'(atk_ready), 32'd0);
    reset = 1'b1; cyc();
    check_val("eval_reset_outs", 32'(all_outs), 32'd0);
    reset = 1'b0; cyc();
    check_val("eval_reset_after", 32'(all_outs), 32'd0);

    // Start with an empty map.
    cfg_start = 1'b1; cyc(); cfg_start = 1'b0;
    check_val("empty_start", 32'({game_over, atk_ready}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
